// File: rtl/stack_cpu_defs.sv
// stack_cpu_defs: shared encodings for the stack CPU command path, ALU opcodes and flag bits.
package stack_cpu_defs;
    typedef enum logic [1:0] {
        K_PUSH = 2'b00,
        K_POP  = 2'b01,
        K_BIN  = 2'b10,
        K_UN   = 2'b11
    } cmd_kind_e;
    typedef enum logic [2:0] {
        ALOP_CPY  = 3'd0,
        ALOP_ADD  = 3'd1,
        ALOP_NEGY = 3'd2,
        ALOP_OR   = 3'd3,
        ALOP_NOTY = 3'd4,
        ALOP_CPX  = 3'd5,
        ALOP_INX  = 3'd6,
        ALOP_DCX  = 3'd7
    } alop_e;
    localparam int FLAG_SF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_OF = 3;
    typedef enum logic [1:0] {S_IDLE, S_OPER, S_EXEC, S_WB} seq_state_e;
endpackage

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand storage with push, pop, TOS replace and binary collapse (pop two, push one).
module operand_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_rep,
    input  logic                     i_rep2,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_tos,
    output logic [W-1:0]             o_nos,
    output logic [$clog2(DEPTH):0]   o_depth
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_depth;
    logic [AW-1:0] w_top, w_nos_idx, w_wr_idx;
    assign w_top     = AW'(r_depth - DW'(1));
    assign w_nos_idx = AW'(r_depth - DW'(2));
    assign w_wr_idx  = i_push ? r_depth[AW-1:0] : i_rep2 ? w_nos_idx : w_top;
    assign o_tos     = r_depth == '0 ? '0 : r_mem[w_top];
    assign o_nos     = r_depth < DW'(2) ? '0 : r_mem[w_nos_idx];
    assign o_depth   = r_depth;
    // Storage is never cleared; only the pointer resets.
    always_ff @(posedge clk) begin
        if (i_push || i_rep || i_rep2) r_mem[w_wr_idx] <= i_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_depth <= '0;
        else if (i_push) r_depth <= r_depth + DW'(1);
        else if (i_pop || i_rep2) r_depth <= r_depth - DW'(1);
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts stack commands and sequences operands through an external ALU.
module alu_op_sequencer
    import stack_cpu_defs::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [2:0]               cmd_alop,
    input  logic [W-1:0]             cmd_data,
    output logic [W-1:0]             alu_x,
    output logic [W-1:0]             alu_y,
    output logic [2:0]               alu_op,
    input  logic [W-1:0]             alu_z,
    input  logic [3:0]               alu_flags,
    output logic [W-1:0]             tos,
    output logic [3:0]               flags,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     err_ovf,
    output logic                     err_unf,
    input  logic                     err_clr
);
    localparam int DW = $clog2(DEPTH) + 1;
    seq_state_e     r_state, w_next;
    logic           w_acc, w_full, w_empty, w_push, w_pop, w_alu, w_ovf, w_unf, w_oper, w_wb;
    logic           r_bin, r_ovf, r_unf;
    logic [2:0]     r_op, r_alu_op;
    logic [3:0]     r_flags;
    logic [W-1:0]   r_x, r_y, w_nos;
    assign w_acc   = cmd_valid && cmd_ready;
    assign w_full  = depth == DW'(DEPTH);
    assign w_empty = depth == '0;
    assign w_push  = w_acc && cmd_kind == K_PUSH && !w_full;
    assign w_ovf   = w_acc && cmd_kind == K_PUSH && w_full;
    assign w_pop   = w_acc && cmd_kind == K_POP && !w_empty;
    assign w_alu   = w_acc && (cmd_kind == K_BIN ? depth >= DW'(2) : cmd_kind == K_UN && !w_empty);
    assign w_unf   = w_acc && cmd_kind != K_PUSH && !w_pop && !w_alu;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == S_IDLE ? (w_alu ? S_OPER : S_IDLE) :
                 r_state == S_OPER ? S_EXEC :
                 r_state == S_EXEC ? S_WB : S_IDLE;
    end
    always_comb begin
        cmd_ready = rst_n && r_state == S_IDLE;
        w_oper    = r_state == S_OPER;
        w_wb      = r_state == S_WB;
    end
    // The command is captured at accept so the ALU opcode is independent of later cmd_* changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin    <= 1'b0;
            r_op     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_alu_op <= '0;
            r_flags  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_alu) begin
                r_bin <= cmd_kind == K_BIN;
                r_op  <= cmd_alop;
            end
            if (w_oper) begin
                r_x      <= r_bin ? w_nos : tos;
                r_y      <= tos;
                r_alu_op <= r_op;
            end
            if (w_wb) r_flags <= alu_flags;
            r_ovf <= w_ovf || (r_ovf && !err_clr);
            r_unf <= w_unf || (r_unf && !err_clr);
        end
    end
    operand_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_rep   (w_wb && !r_bin),
        .i_rep2  (w_wb && r_bin),
        .i_data  (w_push ? cmd_data : alu_z),
        .o_tos   (tos),
        .o_nos   (w_nos),
        .o_depth (depth)
    );
    assign alu_x   = r_x;
    assign alu_y   = r_y;
    assign alu_op  = r_alu_op;
    assign flags   = r_flags;
    assign err_ovf = r_ovf;
    assign err_unf = r_unf;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural ALU and a queue-based stack reference.
module tb_alu_op_sequencer;
    import stack_cpu_defs::*;
    localparam int W = 16;
    localparam int DEPTH = 8;
    logic         clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, err_clr = 1'b0;
    logic [1:0]   cmd_kind = '0;
    logic [2:0]   cmd_alop = '0;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready, err_ovf, err_unf;
    logic [W-1:0] alu_x, alu_y, alu_z, tos;
    logic [2:0]   alu_op;
    logic [3:0]   alu_flags, flags, depth;

    alu_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_alop(cmd_alop), .cmd_data(cmd_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z), .alu_flags(alu_flags),
        .tos(tos), .flags(flags), .depth(depth), .err_ovf(err_ovf), .err_unf(err_unf),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] tos;
        int           depth;
        logic [3:0]   flags;
        logic         ovf;
        logic         unf;
        int           low;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] stk[$];
    logic [3:0]   m_flags = '0;
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    int           checks = 0, errors = 0, low_cnt = 0;
    time          acc_t, t1;

    // Returns {OF, ZF, CF, SF, z}
    function automatic logic [19:0] alu_f(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] r;
        logic ov;
        ov = 1'b0;
        case (op)
            ALOP_CPY:  r = {1'b0, y};
            ALOP_ADD:  begin r = {1'b0, x} + {1'b0, y}; ov = (x[15] == y[15]) && (r[15] != x[15]); end
            ALOP_NEGY: begin r = 17'd0 - {1'b0, y}; ov = y == 16'h8000; end
            ALOP_OR:   r = {1'b0, x | y};
            ALOP_NOTY: r = {1'b0, ~y};
            ALOP_CPX:  r = {1'b0, x};
            ALOP_INX:  begin r = {1'b0, x} + 17'd1; ov = x == 16'h7FFF; end
            default:   begin r = {1'b0, x} - 17'd1; ov = x == 16'h8000; end
        endcase
        return {ov, r[15:0] == 16'd0, r[16], r[15], r[15:0]};
    endfunction

    assign {alu_flags, alu_z} = alu_f(alu_op, alu_x, alu_y);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] k, input logic [2:0] op, input logic [W-1:0] d,
                                  input logic clr, output exp_t e);
        logic nov, nun;
        logic [19:0] r;
        logic [W-1:0] x, y;
        nov = 1'b0;
        nun = 1'b0;
        e.low = 0;
        if (k == K_PUSH) begin
            if (stk.size() == DEPTH) nov = 1'b1;
            else stk.push_back(d);
        end else if (k == K_POP) begin
            if (stk.size() == 0) nun = 1'b1;
            else void'(stk.pop_back());
        end else if (k == K_BIN) begin
            if (stk.size() < 2) nun = 1'b1;
            else begin
                y = stk.pop_back();
                x = stk.pop_back();
                r = alu_f(op, x, y);
                stk.push_back(r[15:0]);
                m_flags = r[19:16];
                e.low = 3;
            end
        end else begin
            if (stk.size() == 0) nun = 1'b1;
            else begin
                x = stk.pop_back();
                r = alu_f(op, x, x);
                stk.push_back(r[15:0]);
                m_flags = r[19:16];
                e.low = 3;
            end
        end
        m_ovf = nov || (m_ovf && !clr);
        m_unf = nun || (m_unf && !clr);
        e.tos = stk.size() > 0 ? stk[$] : '0;
        e.depth = stk.size();
        e.flags = m_flags;
        e.ovf = m_ovf;
        e.unf = m_unf;
    endfunction

    task automatic send(input logic [1:0] k, input logic [2:0] op, input logic [W-1:0] d,
                        input logic clr = 1'b0, input logic hold = 1'b0, input logic track = 1'b1);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_ready", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_kind = k;
        cmd_alop = op;
        cmd_data = d;
        err_clr = clr;
        @(posedge clk);
        acc_t = $time;
        if (track) begin
            model(k, op, d, clr, e);
            sb.push_back(e);
        end
        #1;
        err_clr = 1'b0;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) chk("drain_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stk.delete();
        sb.delete();
        m_flags = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: the first cycle with cmd_ready high after an accept shows that command's result.
    always @(negedge clk) begin
        if (!rst_n) low_cnt = 0;
        else if (sb.size() > 0) begin
            if (!cmd_ready && low_cnt < 8) low_cnt++;
            else begin
                mon_e = sb.pop_front();
                chk("sb_tos", tos, mon_e.tos);
                chk("sb_depth", depth, mon_e.depth);
                chk("sb_flags", flags, mon_e.flags);
                chk("sb_err_ovf", err_ovf, mon_e.ovf);
                chk("sb_err_unf", err_unf, mon_e.unf);
                chk("sb_ready_low", low_cnt, mon_e.low);
                low_cnt = 0;
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_depth", depth, 0);
        chk("rst_tos", tos, 0);
        chk("rst_flags", flags, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_errs", {err_ovf, err_unf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(K_PUSH, 3'd0, 16'h04B0);
        send(K_PUSH, 3'd0, 16'h3997);
        send(K_BIN, ALOP_ADD, '0);
        drain();
        chk("add_tos", tos, 16'h3E47);
        chk("add_depth", depth, 1);
        chk("add_flags", flags, 4'b0000);

        do_reset();
        send(K_PUSH, 3'd0, 16'hFFFF);
        send(K_UN, ALOP_INX, '0);
        drain();
        chk("inx_tos", tos, 16'h0000);
        chk("inx_zf", flags[FLAG_ZF], 1);
        chk("inx_depth", depth, 1);

        do_reset();
        for (int i = 1; i <= 9; i++) send(K_PUSH, 3'd0, 16'(i));
        drain();
        chk("full_depth", depth, 8);
        chk("full_tos", tos, 16'h0008);
        chk("full_ovf", err_ovf, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk("clr_ovf", err_ovf, 0);
        send(K_PUSH, 3'd0, 16'h00AA, 1'b1);
        drain();
        chk("set_wins_ovf", err_ovf, 1);

        do_reset();
        send(K_PUSH, 3'd0, 16'h1234);
        send(K_BIN, ALOP_OR, '0);
        drain();
        chk("unf_flag", err_unf, 1);
        chk("unf_tos", tos, 16'h1234);
        chk("unf_depth", depth, 1);

        do_reset();
        send(K_PUSH, 3'd0, 16'hFFFF);
        send(K_UN, ALOP_INX, '0);
        send(K_PUSH, 3'd0, 16'h0005);
        send(K_PUSH, 3'd0, 16'h0003);
        drain();
        send(K_BIN, ALOP_ADD, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_depth", depth, 0);
        chk("midrst_tos", tos, 0);
        chk("midrst_flags", flags, 0);
        chk("midrst_ready", cmd_ready, 0);
        stk.delete();
        m_flags = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_idle", cmd_ready, 1);
        chk("midrst_depth2", depth, 0);
        chk("midrst_tos2", tos, 0);

        send(K_PUSH, 3'd0, 16'd1);
        send(K_PUSH, 3'd0, 16'd2);
        send(K_PUSH, 3'd0, 16'd3);
        drain();
        send(K_BIN, ALOP_ADD, '0, 1'b0, 1'b1);
        t1 = acc_t;
        send(K_BIN, ALOP_ADD, '0);
        chk("b2b_gap", 32'((acc_t - t1) / 10), 4);
        drain();
        chk("b2b_tos", tos, 16'h0006);

        do_reset();
        repeat (300) begin
            logic [1:0] k;
            k = $urandom_range(0, 9) < 4 ? 2'(K_PUSH) : 2'($urandom_range(0, 3));
            send(k, 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 7) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
